// File: rtl/elevator_pkg.sv
// Shared defaults and types for the elevator request scheduler.
// ELEVATOR_SCAN_EN selects directional SCAN picking; default is lowest-index priority.
package elevator_pkg;
  localparam int DEF_NUM_FLOORS = 4;
  localparam int DEF_FLOOR_W    = $clog2(DEF_NUM_FLOORS);

  typedef logic [DEF_FLOOR_W-1:0] floor_t;
  typedef enum logic [1:0] {IDLE, DISPATCH, MOVING, DWELL} sched_state_t;
  typedef enum logic {UP, DOWN} dir_t;
endpackage

// File: rtl/elevator_floor_picker.sv
// Combinational next-target selection from the pending set.
// ELEVATOR_SCAN_EN: nearest floor in travel direction, else reverse; otherwise lowest index wins.
module elevator_floor_picker
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
  parameter int FLOOR_W    = DEF_FLOOR_W
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    cur_i,
`ifdef ELEVATOR_SCAN_EN
  input  dir_t                  dir_i,
  output dir_t                  new_dir_o,
`endif
  output logic                  valid_o,
  output logic [FLOOR_W-1:0]    floor_o
);
`ifdef ELEVATOR_SCAN_EN
  logic               up_vld, dn_vld;
  logic [FLOOR_W-1:0] up_f, dn_f;

  // Last hit wins: scan high->low for the nearest above, low->high for the nearest below.
  always_comb begin
    up_vld = 1'b0;
    dn_vld = 1'b0;
    up_f   = '0;
    dn_f   = '0;
    for (int i = NUM_FLOORS-1; i >= 0; i--)
      if (pending_i[i] && i > int'(cur_i)) begin
        up_vld = 1'b1;
        up_f   = FLOOR_W'(i);
      end
    for (int i = 0; i < NUM_FLOORS; i++)
      if (pending_i[i] && i < int'(cur_i)) begin
        dn_vld = 1'b1;
        dn_f   = FLOOR_W'(i);
      end
  end

  always_comb begin
    valid_o = up_vld | dn_vld;
    if (dir_i == UP) floor_o = up_vld ? up_f : dn_f;
    else             floor_o = dn_vld ? dn_f : up_f;
    new_dir_o = (floor_o > cur_i) ? UP : DOWN;
  end
`else
  always_comb begin
    valid_o = 1'b0;
    floor_o = '0;
    for (int i = NUM_FLOORS-1; i >= 0; i--)
      if (pending_i[i] && i != int'(cur_i)) begin
        valid_o = 1'b1;
        floor_o = FLOOR_W'(i);
      end
  end
`endif
endmodule

// File: rtl/elevator_request_scheduler.sv
// Latches floor calls and issues one target at a time, holding it until arrival, then dwelling.
// ELEVATOR_SCAN_EN adds a direction register and SCAN ordering in the picker.
module elevator_request_scheduler
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS     = DEF_NUM_FLOORS,
  parameter int FLOOR_W        = DEF_FLOOR_W,
  parameter int DWELL_CYCLES   = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [NUM_FLOORS-1:0] i_call,
  input  logic [FLOOR_W-1:0]    i_current_floor,
  output logic [FLOOR_W-1:0]    o_target_floor,
  output logic [NUM_FLOORS-1:0] o_pending,
  output logic                  o_busy,
  output logic                  o_fault
);
  localparam int CNT_MAX = (DWELL_CYCLES > TIMEOUT_CYCLES) ? DWELL_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

  sched_state_t          state_q, state_d;
  logic [NUM_FLOORS-1:0] pending_q, pending_d, clr;
  logic [FLOOR_W-1:0]    target_q, target_d;
  logic [CNT_W-1:0]      tmo_q, tmo_d, dwell_q, dwell_d;
  logic                  fault_q, fault_d;
  logic                  pick_vld, arrived;
  logic [FLOOR_W-1:0]    pick_floor;
`ifdef ELEVATOR_SCAN_EN
  dir_t                  dir_q, dir_d, pick_dir;
`endif

  elevator_floor_picker #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_picker (
    .pending_i (pending_q),
    .cur_i     (i_current_floor),
`ifdef ELEVATOR_SCAN_EN
    .dir_i     (dir_q),
    .new_dir_o (pick_dir),
`endif
    .valid_o   (pick_vld),
    .floor_o   (pick_floor)
  );

  assign arrived = (i_current_floor == target_q);

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      target_q  <= '0;
      tmo_q     <= '0;
      dwell_q   <= '0;
      fault_q   <= 1'b0;
`ifdef ELEVATOR_SCAN_EN
      dir_q     <= UP;
`endif
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      target_q  <= target_d;
      tmo_q     <= tmo_d;
      dwell_q   <= dwell_d;
      fault_q   <= fault_d;
`ifdef ELEVATOR_SCAN_EN
      dir_q     <= dir_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (pending_q[i_current_floor]) state_d = DWELL;
                else if (|pending_q)            state_d = DISPATCH;
      DISPATCH: state_d = pick_vld ? MOVING : IDLE;
      MOVING:   if (arrived)                 state_d = DWELL;
                else if (tmo_q == TMO_LAST)  state_d = IDLE;
      DWELL:    if (dwell_q == DWELL_LAST)   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Clearing a floor beats a same-cycle call on that floor.
  always_comb begin
    clr      = '0;
    target_d = target_q;
    tmo_d    = tmo_q;
    dwell_d  = dwell_q;
    fault_d  = fault_q;
`ifdef ELEVATOR_SCAN_EN
    dir_d    = dir_q;
`endif
    case (state_q)
      IDLE: if (pending_q[i_current_floor]) begin
        clr[i_current_floor] = 1'b1;
        dwell_d              = '0;
      end
      DISPATCH: begin
        tmo_d = '0;
        if (pick_vld) begin
          target_d = pick_floor;
`ifdef ELEVATOR_SCAN_EN
          dir_d    = pick_dir;
`endif
        end
      end
      MOVING: begin
        if (arrived) begin
          clr[target_q] = 1'b1;
          dwell_d       = '0;
        end else if (tmo_q == TMO_LAST) begin
          clr[target_q] = 1'b1;
          fault_d       = 1'b1;
        end else if (tmo_q != '1) begin
          tmo_d = tmo_q + CNT_W'(1);
        end
      end
      DWELL: if (dwell_q != '1) dwell_d = dwell_q + CNT_W'(1);
      default: ;
    endcase
    pending_d = (pending_q | i_call) & ~clr;
  end

  always_comb begin
    o_busy         = (state_q != IDLE);
    o_target_floor = target_q;
    o_pending      = pending_q;
    o_fault        = fault_q;
  end
endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Scheduler bench: elevator car model plus a dispatch scoreboard; honours ELEVATOR_SCAN_EN.
module tb_elevator_request_scheduler;
  localparam int NF = 4, FW = 2, DWELL = 8, TMO = 64;

  logic          clk = 1'b0, rst = 1'b1;
  logic [NF-1:0] call = '0;
  logic [FW-1:0] car = '0, tp_val = '0;
  logic          frozen = 1'b0, tp_req = 1'b0, busy_d1 = 1'b0;
  logic [FW-1:0] tgt;
  logic [NF-1:0] pend;
  logic          busy, fault;
  logic          mon_arm = 1'b0, mon_bprev = 1'b0;
  int            nchk = 0, nerr = 0;
  int            exp_q[$];
  int            first_f, second_f, last_tgt;

  always #5 clk = ~clk;

  elevator_request_scheduler #(
    .NUM_FLOORS(NF), .FLOOR_W(FW), .DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_call(call), .i_current_floor(car),
    .o_target_floor(tgt), .o_pending(pend), .o_busy(busy), .o_fault(fault)
  );

  // Car steps one floor per cycle toward the command once busy has been high for two samples.
  always @(posedge clk) begin
    busy_d1 <= busy;
    if (tp_req) car <= tp_val;
    else if (!frozen && busy && busy_d1 && car != tgt)
      car <= (tgt > car) ? car + 2'd1 : car - 2'd1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Each busy rise is one service; the command is sampled one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      mon_arm   <= 1'b0;
      mon_bprev <= 1'b0;
    end else begin
      if (mon_arm) begin
        if (exp_q.size() == 0) chk("unexpected_dispatch", int'(tgt), -1);
        else                   chk("dispatch_target", int'(tgt), exp_q.pop_front());
      end
      mon_arm   <= busy && !mon_bprev;
      mon_bprev <= busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_call(input logic [NF-1:0] v);
    call = v;
    tick();
    call = '0;
  endtask

  task automatic teleport(input logic [FW-1:0] f);
    tp_req = 1'b1;
    tp_val = f;
    tick();
    tp_req = 1'b0;
  endtask

  task automatic wait_car(input int f, input string nm);
    int n = 0;
    while (int'(car) != f && n < 200) begin
      tick();
      n++;
    end
    chk(nm, int'(car), f);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(nm, int'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("reset_target", int'(tgt), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_pending", int'(pend), 0);
    chk("reset_fault", int'(fault), 0);

    // single call from floor 0
    exp_q.push_back(2);
    pulse_call(4'b0100);
    chk("latch_pending", int'(pend), 'h4);
    tick();
    tick();
    chk("target_latency", int'(tgt), 2);
    wait_car(2, "arrive_2");
    tick();
    chk("pending_cleared", int'(pend), 0);
    n = 1;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    chk("dwell_to_idle", n, DWELL + 1);

    // two calls from floor 0
    teleport(2'd0);
    exp_q.push_back(1);
    exp_q.push_back(3);
    pulse_call(4'b1010);
    chk("latch_pending_two", int'(pend), 'ha);
    wait_car(1, "arrive_1");
    wait_car(3, "arrive_3");
    wait_idle("idle_after_pair");
    chk("pending_empty_pair", int'(pend), 0);

    // go 3->2 so the car is at 2 heading down, then {0,3}
    exp_q.push_back(2);
    pulse_call(4'b0100);
    wait_car(2, "arrive_2_down");
    wait_idle("idle_at_2");
    exp_q.push_back(0);
    exp_q.push_back(3);
    pulse_call(4'b1001);
    wait_car(0, "arrive_0");
    wait_car(3, "arrive_3_again");
    wait_idle("idle_after_down");

    // go 1->2 so the car is at 2 heading up, then {1,3}
    teleport(2'd1);
    exp_q.push_back(2);
    pulse_call(4'b0100);
    wait_car(2, "arrive_2_up");
    wait_idle("idle_at_2_up");
`ifdef ELEVATOR_SCAN_EN
    first_f = 3; second_f = 1; last_tgt = 1;
`else
    first_f = 1; second_f = 3; last_tgt = 3;
`endif
    exp_q.push_back(first_f);
    exp_q.push_back(second_f);
    pulse_call(4'b1010);
    wait_car(first_f, "arrive_first");
    wait_car(second_f, "arrive_second");
    wait_idle("idle_after_up");

    // call on the current floor while idle
    teleport(2'd1);
    exp_q.push_back(last_tgt);
    pulse_call(4'b0010);
    chk("local_latched", int'(pend), 'h2);
    tick();
    chk("local_cleared", int'(pend), 0);
    chk("local_dwell_busy", int'(busy), 1);
    wait_idle("idle_after_local");

    // frozen car: request must time out
    teleport(2'd0);
    frozen = 1'b1;
    exp_q.push_back(3);
    pulse_call(4'b1000);
    n = 0;
    while (!fault && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TMO + 2);
    chk("timeout_pending", int'(pend), 0);
    chk("timeout_idle", int'(busy), 0);

    // reset while moving
    exp_q.push_back(2);
    pulse_call(4'b0100);
    repeat (5) tick();
    pulse_call(4'b0010);
    chk("moving_pending", int'(pend), 'h6);
    chk("fault_sticky", int'(fault), 1);
    chk("moving_busy", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk("rst_target", int'(tgt), 0);
    chk("rst_pending", int'(pend), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_fault", int'(fault), 0);
    rst = 1'b0;
    frozen = 1'b0;
    repeat (3) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
